fetch_decode_pipe_ctrl: RTL and testbench

//  Front-end pipeline controller. Turns stall, mispredict, exception and fence.i requests into
//  the lock_PIPELINE / FLUSH_P1 / FLUSH_P2 controls of the fetch->decode latch, plus the fetch
//  PC redirect. Sits beside the fetch-decode latch; driven by decode, execute and commit.

---
 rtl/fetch_decode_pipe_ctrl_pkg.sv | 10 +
 rtl/fetch_decode_pipe_ctrl_if.sv | 31 +++
 rtl/fetch_decode_pipe_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_decode_pipe_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pipe_ctrl_pkg.sv
// fetch_decode_pipe_ctrl_pkg: shared FSM state encoding, default address width and request priority encoder
package fetch_decode_pipe_ctrl_pkg;
  localparam int ADDR_W_DEF = 40;
  typedef enum logic [1:0] {ST_IDLE, ST_BR_PEND, ST_XCPT, ST_FENCE} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_BR, EV_FENCE, EV_XCPT} event_e;
  // exception beats fence.i, which beats a branch mispredict
  function automatic event_e pick_event(input logic xcpt, input logic fence, input logic br);
    return xcpt ? EV_XCPT : fence ? EV_FENCE : br ? EV_BR : EV_NONE;
  endfunction
endpackage

// File: rtl/fetch_decode_pipe_ctrl_if.sv
// fetch_decode_pipe_ctrl_if: request/control bundle between decode/execute/commit and the front-end controller
// master drives stall/event requests and sees flush/lock/redirect; slave is the controller
interface fetch_decode_pipe_ctrl_if #(parameter int ADDR_W = 40);
  logic              dec_stall_req;
  logic              exe_stall_req;
  logic              mem_stall_req;
  logic              br_mispredict;
  logic [ADDR_W-1:0] br_target;
  logic              xcpt_req;
  logic [ADDR_W-1:0] xcpt_pc;
  logic              fence_i_req;
  logic [ADDR_W-1:0] fence_next_pc;
  logic              icache_flush_done;
  logic              lock_PIPELINE;
  logic              FLUSH_P1;
  logic              FLUSH_P2;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              icache_flush;
  logic              ctrl_busy;
  modport master (
    output dec_stall_req, exe_stall_req, mem_stall_req, br_mispredict, br_target,
           xcpt_req, xcpt_pc, fence_i_req, fence_next_pc, icache_flush_done,
    input  lock_PIPELINE, FLUSH_P1, FLUSH_P2, redirect_valid, redirect_pc, icache_flush, ctrl_busy
  );
  modport slave (
    input  dec_stall_req, exe_stall_req, mem_stall_req, br_mispredict, br_target,
           xcpt_req, xcpt_pc, fence_i_req, fence_next_pc, icache_flush_done,
    output lock_PIPELINE, FLUSH_P1, FLUSH_P2, redirect_valid, redirect_pc, icache_flush, ctrl_busy
  );
endinterface

// File: rtl/fetch_decode_pipe_ctrl.sv
// fetch_decode_pipe_ctrl: turns stall/mispredict/exception/fence.i requests into fetch->decode latch lock/flush and fetch redirect
// ports: CLK, RST (async active-high), bus (slave side of fetch_decode_pipe_ctrl_if)
module fetch_decode_pipe_ctrl
  import fetch_decode_pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int XCPT_FLUSH_N = 2
) (
  input logic                   CLK,
  input logic                   RST,
  fetch_decode_pipe_ctrl_if.slave bus
);
  localparam int CW = $clog2(XCPT_FLUSH_N + 1);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d, pc_q, pc_d;
  logic              fp1_q, fp1_d, fp2_q, fp2_d, rv_q, rv_d, icf_q, icf_d;
  logic              stall;
  event_e            ev;
  assign stall = bus.dec_stall_req | bus.exe_stall_req | bus.mem_stall_req;
  assign ev    = pick_event(bus.xcpt_req, bus.fence_i_req, bus.br_mispredict);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    fp1_d   = 1'b0;
    fp2_d   = 1'b0;
    rv_d    = 1'b0;
    icf_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_BR_PEND: begin
        if (ev == EV_XCPT) begin
          state_d = ST_XCPT;
          fp1_d   = 1'b1;
          rv_d    = 1'b1;
          pc_d    = bus.xcpt_pc;
          cnt_d   = CW'(XCPT_FLUSH_N - 1);
        end else if (ev == EV_FENCE) begin
          state_d = ST_FENCE;
          fp1_d   = 1'b1;
          icf_d   = 1'b1;
        end else if (state_q == ST_BR_PEND) begin
          // younger mispredicts are ignored; release the captured target once stalls clear
          if (!stall) begin
            state_d = ST_IDLE;
            fp2_d   = 1'b1;
            rv_d    = 1'b1;
            pc_d    = tgt_q;
          end
        end else if (ev == EV_BR) begin
          if (stall) begin
            state_d = ST_BR_PEND;
            tgt_d   = bus.br_target;
          end else begin
            fp2_d = 1'b1;
            rv_d  = 1'b1;
            pc_d  = bus.br_target;
          end
        end
      end
      ST_XCPT: begin
        fp1_d   = cnt_q != '0;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        state_d = (cnt_q == '0) ? ST_IDLE : ST_XCPT;
      end
      ST_FENCE: begin
        if (bus.icache_flush_done) begin
          state_d = ST_IDLE;
          rv_d    = 1'b1;
          pc_d    = bus.fence_next_pc;
        end else begin
          icf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pc_q    <= '0;
      fp1_q   <= 1'b0;
      fp2_q   <= 1'b0;
      rv_q    <= 1'b0;
      icf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      fp1_q   <= fp1_d;
      fp2_q   <= fp2_d;
      rv_q    <= rv_d;
      icf_q   <= icf_d;
    end
  end
  assign bus.lock_PIPELINE  = stall | (state_q == ST_FENCE);
  assign bus.FLUSH_P1       = fp1_q;
  assign bus.FLUSH_P2       = fp2_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = pc_q;
  assign bus.icache_flush   = icf_q;
  assign bus.ctrl_busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_fetch_decode_pipe_ctrl.sv
// tb_fetch_decode_pipe_ctrl: vector table, hand sequences and random traffic against a behavioural model
module tb_fetch_decode_pipe_ctrl;
  localparam int AW = 40;
  localparam int XN = 2;
  typedef struct {
    logic [6:0]    in;   // {dec,exe,mem,br,xcpt,fence,done}
    logic [AW-1:0] tgt;
    logic [AW-1:0] xpc;
    logic [5:0]    ex;   // {lock,fp1,fp2,rv,icf,busy}
    logic [AW-1:0] pc;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  logic last_lock;
  bit m_fp1, m_fp2, m_rv, m_icf, m_fence, m_pend;
  logic [AW-1:0] m_pc, m_ptgt;
  int m_xleft;
  int m_redirects = 0;
  int dut_redirects = 0;
  vec_t tbl[17];
  fetch_decode_pipe_ctrl_if #(.ADDR_W(AW)) bus();
  fetch_decode_pipe_ctrl #(.ADDR_W(AW), .XCPT_FLUSH_N(XN)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    {m_fp1, m_fp2, m_rv, m_icf, m_fence, m_pend} = '0;
    m_pc = '0;
    m_ptgt = '0;
    m_xleft = 0;
  endtask
  // expected registered outputs for the cycle after the edge, from the request rules
  task automatic model_update();
    bit stall;
    stall = bus.dec_stall_req | bus.exe_stall_req | bus.mem_stall_req;
    {m_fp1, m_fp2, m_rv, m_icf} = '0;
    if (m_xleft > 0) begin
      m_xleft--;
      m_fp1 = m_xleft > 0;
    end else if (m_fence) begin
      if (bus.icache_flush_done) begin
        m_rv = 1; m_pc = bus.fence_next_pc; m_fence = 0;
      end else m_icf = 1;
    end else if (bus.xcpt_req) begin
      m_xleft = XN; m_pend = 0; m_fp1 = 1; m_rv = 1; m_pc = bus.xcpt_pc;
    end else if (bus.fence_i_req) begin
      m_fence = 1; m_pend = 0; m_fp1 = 1; m_icf = 1;
    end else if (m_pend) begin
      if (!stall) begin
        m_fp2 = 1; m_rv = 1; m_pc = m_ptgt; m_pend = 0;
      end
    end else if (bus.br_mispredict) begin
      if (stall) begin
        m_pend = 1; m_ptgt = bus.br_target;
      end else begin
        m_fp2 = 1; m_rv = 1; m_pc = bus.br_target;
      end
    end
    if (m_rv) m_redirects++;
  endtask
  task automatic clear_inputs();
    {bus.dec_stall_req, bus.exe_stall_req, bus.mem_stall_req, bus.br_mispredict,
     bus.xcpt_req, bus.fence_i_req, bus.icache_flush_done} = '0;
  endtask
  // called right after a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    bit stall;
    #1;
    stall = bus.dec_stall_req | bus.exe_stall_req | bus.mem_stall_req;
    last_lock = bus.lock_PIPELINE;
    chk("lock", 64'(bus.lock_PIPELINE), 64'(stall | m_fence));
    @(posedge CLK);
    model_update();
    #1;
    chk("flush_p1", 64'(bus.FLUSH_P1), 64'(m_fp1));
    chk("flush_p2", 64'(bus.FLUSH_P2), 64'(m_fp2));
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
    chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_pc));
    chk("icache_flush", 64'(bus.icache_flush), 64'(m_icf));
    chk("ctrl_busy", 64'(bus.ctrl_busy), 64'(m_fence | m_pend | (m_xleft > 0)));
    chk("p1_p2_exclusive", 64'(bus.FLUSH_P1 & bus.FLUSH_P2), 64'(0));
    if (bus.redirect_valid) dut_redirects++;
    @(negedge CLK);
  endtask
  task automatic pulse_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    chk({tag, "_outs"}, 64'({bus.FLUSH_P1, bus.FLUSH_P2, bus.redirect_valid, bus.icache_flush,
                              bus.ctrl_busy, bus.lock_PIPELINE}), 64'(0));
    chk({tag, "_pc"}, 64'(bus.redirect_pc), 64'(0));
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask
  initial begin
    logic [63:0] r64;
    int lock_cnt, icf_cnt, rv_cnt;
    tbl[0]  = '{7'b0000000, '0, '0, 6'b000000, '0};
    tbl[1]  = '{7'b0001000, 40'h80_0000_0100, '0, 6'b001100, 40'h80_0000_0100};
    tbl[2]  = '{7'b0000000, '0, '0, 6'b000000, 40'h80_0000_0100};
    tbl[3]  = '{7'b0011000, 40'h1234, '0, 6'b100001, 40'h80_0000_0100};
    tbl[4]  = '{7'b0010000, '0, '0, 6'b100001, 40'h80_0000_0100};
    tbl[5]  = '{7'b0011000, 40'hdead, '0, 6'b100001, 40'h80_0000_0100};
    tbl[6]  = '{7'b0010000, '0, '0, 6'b100001, 40'h80_0000_0100};
    tbl[7]  = '{7'b0010000, '0, '0, 6'b100001, 40'h80_0000_0100};
    tbl[8]  = '{7'b0000000, '0, '0, 6'b001100, 40'h1234};
    tbl[9]  = '{7'b0001100, 40'h999, 40'h100, 6'b010101, 40'h100};
    tbl[10] = '{7'b0001000, 40'h777, '0, 6'b010001, 40'h100};
    tbl[11] = '{7'b0000000, '0, '0, 6'b000000, 40'h100};
    tbl[12] = '{7'b1101000, 40'h55, '0, 6'b100001, 40'h100};
    tbl[13] = '{7'b0000100, '0, 40'h180, 6'b010101, 40'h180};
    tbl[14] = '{7'b0000000, '0, '0, 6'b010001, 40'h180};
    tbl[15] = '{7'b0000000, '0, '0, 6'b000000, 40'h180};
    tbl[16] = '{7'b0000000, '0, '0, 6'b000000, 40'h180};
    clear_inputs();
    bus.br_target = '0;
    bus.xcpt_pc = '0;
    bus.fence_next_pc = 40'h204;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_outs", 64'({bus.FLUSH_P1, bus.FLUSH_P2, bus.redirect_valid, bus.icache_flush,
                           bus.ctrl_busy, bus.lock_PIPELINE}), 64'(0));
    chk("reset_pc", 64'(bus.redirect_pc), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 17; i++) begin
      {bus.dec_stall_req, bus.exe_stall_req, bus.mem_stall_req, bus.br_mispredict,
       bus.xcpt_req, bus.fence_i_req, bus.icache_flush_done} = tbl[i].in;
      bus.br_target = tbl[i].tgt;
      bus.xcpt_pc = tbl[i].xpc;
      step();
      chk($sformatf("tbl%0d_flags", i), 64'({last_lock, bus.FLUSH_P1, bus.FLUSH_P2, bus.redirect_valid,
                                             bus.icache_flush, bus.ctrl_busy}), 64'(tbl[i].ex));
      chk($sformatf("tbl%0d_pc", i), 64'(bus.redirect_pc), 64'(tbl[i].pc));
    end
    clear_inputs();
    lock_cnt = 0;
    icf_cnt = 0;
    for (int k = 0; k <= 8; k++) begin
      bus.fence_i_req = (k == 0);
      bus.icache_flush_done = (k == 7);
      step();
      lock_cnt += int'(last_lock);
      icf_cnt += int'(bus.icache_flush);
      if (k == 0) chk("fence_entry_p1", 64'(bus.FLUSH_P1), 64'(1));
      if (k == 7) chk("fence_redirect", 64'({bus.redirect_valid, bus.ctrl_busy, bus.redirect_pc}),
                      64'({1'b1, 1'b0, 40'h204}));
    end
    chk("fence_lock_cycles", 64'(lock_cnt), 64'(7));
    chk("fence_icf_cycles", 64'(icf_cnt), 64'(7));
    clear_inputs();
    bus.xcpt_req = 1'b1;
    bus.xcpt_pc = 40'h300;
    step();
    clear_inputs();
    pulse_reset("rst_xcpt");
    rv_cnt = 0;
    repeat (4) begin
      step();
      rv_cnt += int'(bus.redirect_valid);
    end
    bus.fence_i_req = 1'b1;
    step();
    clear_inputs();
    step();
    pulse_reset("rst_fence");
    bus.icache_flush_done = 1'b1;
    step();
    rv_cnt += int'(bus.redirect_valid);
    clear_inputs();
    repeat (3) begin
      step();
      rv_cnt += int'(bus.redirect_valid);
    end
    chk("no_redirect_after_reset", 64'(rv_cnt), 64'(0));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499, 0) == 0) begin
        clear_inputs();
        pulse_reset("rst_rand");
      end
      bus.dec_stall_req = $urandom_range(9, 0) < 2;
      bus.exe_stall_req = $urandom_range(9, 0) < 2;
      bus.mem_stall_req = $urandom_range(9, 0) < 2;
      bus.br_mispredict = $urandom_range(9, 0) < 2;
      bus.xcpt_req = $urandom_range(19, 0) == 0;
      bus.fence_i_req = $urandom_range(19, 0) == 0;
      bus.icache_flush_done = $urandom_range(5, 0) == 0;
      r64 = {$urandom(), $urandom()};
      bus.br_target = r64[AW-1:0];
      r64 = {$urandom(), $urandom()};
      bus.xcpt_pc = r64[AW-1:0];
      r64 = {$urandom(), $urandom()};
      bus.fence_next_pc = r64[AW-1:0];
      step();
    end
    chk("redirect_count", 64'(dut_redirects), 64'(m_redirects));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
